// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; result packed {remainder, quotient}.
// Optional early-out for |dividend| < |divisor| is enabled by defining DIV_EARLY_OUT_EN.
module div_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  state_t              r_state, w_state_next;
  logic [CNT_W-1:0]    r_cnt, w_cnt_next;
  logic [DATA_W-1:0]   r_rem, w_rem_next;
  logic [DATA_W-1:0]   r_dvd, w_dvd_next;
  logic [DATA_W-1:0]   r_dvs, w_dvs_next;
  logic                r_sign_q, w_sign_q_next;
  logic                r_sign_r, w_sign_r_next;
  logic [2*DATA_W-1:0] r_result, w_result_next;
  logic                r_ready, w_ready_next;
`ifdef DIV_EARLY_OUT_EN
  logic [DATA_W-1:0]   r_orig, w_orig_next;
`endif

  // Operand magnitudes; the most negative value maps to itself, which is correct unsigned.
  logic              w_neg1, w_neg2;
  logic [DATA_W-1:0] w_abs1, w_abs2;
  assign w_neg1 = signed_div_i & opdata1_i[DATA_W-1];
  assign w_neg2 = signed_div_i & opdata2_i[DATA_W-1];
  assign w_abs1 = w_neg1 ? (~opdata1_i + 1'b1) : opdata1_i;
  assign w_abs2 = w_neg2 ? (~opdata2_i + 1'b1) : opdata2_i;

  // Bit DATA_W of the trial difference is set exactly when the shifted remainder < divisor.
  logic [DATA_W:0]   w_shift, w_diff;
  logic              w_ge;
  assign w_shift = {r_rem, r_dvd[DATA_W-1]};
  assign w_diff  = w_shift - {1'b0, r_dvs};
  assign w_ge    = ~w_diff[DATA_W];

  logic [DATA_W-1:0] w_quo_fix, w_rem_fix;
  assign w_quo_fix = r_sign_q ? (~r_dvd + 1'b1) : r_dvd;
  assign w_rem_fix = r_sign_r ? (~r_rem + 1'b1) : r_rem;

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_rem_next    = r_rem;
    w_dvd_next    = r_dvd;
    w_dvs_next    = r_dvs;
    w_sign_q_next = r_sign_q;
    w_sign_r_next = r_sign_r;
    w_result_next = r_result;
    w_ready_next  = r_ready;
`ifdef DIV_EARLY_OUT_EN
    w_orig_next   = r_orig;
`endif
    case (r_state)
      S_FREE: begin
        w_result_next = '0;
        w_ready_next  = 1'b0;
        w_cnt_next    = '0;
        w_rem_next    = '0;
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            w_state_next = S_BYZERO;
          end else begin
            w_state_next  = S_ON;
            w_dvd_next    = w_abs1;
            w_dvs_next    = w_abs2;
            w_sign_q_next = w_neg1 ^ w_neg2;
            w_sign_r_next = w_neg1;
`ifdef DIV_EARLY_OUT_EN
            w_orig_next   = opdata1_i;
`endif
          end
        end
      end
      S_BYZERO: begin
        if (annul_i) begin
          w_state_next = S_FREE;
        end else begin
          w_state_next  = S_END;
          w_result_next = '0;
          w_ready_next  = 1'b1;
        end
      end
      S_ON: begin
        if (annul_i) begin
          w_state_next  = S_FREE;
          w_ready_next  = 1'b0;
          w_result_next = '0;
          w_cnt_next    = '0;
`ifdef DIV_EARLY_OUT_EN
        end else if (r_cnt == '0 && r_dvd < r_dvs) begin
          // Quotient is zero and the remainder is the dividend as given.
          w_state_next  = S_END;
          w_result_next = {r_orig, {DATA_W{1'b0}}};
          w_ready_next  = 1'b1;
`endif
        end else if (r_cnt == CNT_W'(DATA_W)) begin
          w_state_next  = S_END;
          w_result_next = {w_rem_fix, w_quo_fix};
          w_ready_next  = 1'b1;
        end else begin
          w_rem_next = w_ge ? w_diff[DATA_W-1:0] : w_shift[DATA_W-1:0];
          w_dvd_next = {r_dvd[DATA_W-2:0], w_ge};
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      S_END: begin
        if (!start_i) begin
          w_state_next  = S_FREE;
          w_ready_next  = 1'b0;
          w_result_next = '0;
        end
      end
      default: w_state_next = S_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_FREE;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_result <= '0;
      r_ready  <= 1'b0;
`ifdef DIV_EARLY_OUT_EN
      r_orig   <= '0;
`endif
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_rem    <= w_rem_next;
      r_dvd    <= w_dvd_next;
      r_dvs    <= w_dvs_next;
      r_sign_q <= w_sign_q_next;
      r_sign_r <= w_sign_r_next;
      r_result <= w_result_next;
      r_ready  <= w_ready_next;
`ifdef DIV_EARLY_OUT_EN
      r_orig   <= w_orig_next;
`endif
    end
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: latency, signed/unsigned results,
// divide-by-zero, annul, reset mid-division and back-to-back operation.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int errors = 0;
  int checks = 0;

`ifdef DIV_EARLY_OUT_EN
  localparam int SMALL_LAT = 1;
`else
  localparam int SMALL_LAT = 33;
`endif

  div_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  // Caller is at a negedge. Start edge is the next posedge (edge 0); lat is the
  // first edge after it at which ready_o is seen, -1 on timeout. Operands are
  // scrambled after the start edge. start_i is left high.
  task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [63:0] res);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    opdata1_i    = $urandom;
    opdata2_i    = $urandom;
    signed_div_i = ~sgn;
    lat = -1;
    res = '0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ready_o) begin
        lat = i;
        res = result_o;
        break;
      end
    end
  endtask

  task automatic release_op();
    start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b1; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = 32'd100; opdata2_i = 32'd7;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b want=0", ready_o); end
    checks++;
    if (result_o !== 64'd0) begin errors++; $display("FAIL reset_result got=%h want=0", result_o); end
    start_i = 1'b0; rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b0) begin errors++; $display("FAIL post_reset_ready got=%b want=0", ready_o); end
    $display("reset: ready=%b result=%h", ready_o, result_o);
  endtask

  task automatic test_unsigned();
    int lat;
    logic [63:0] res;
    logic held;
    do_div(1'b0, 32'd100, 32'd7, lat, res);
    $display("udiv 100/7: lat=%0d result=%h", lat, res);
    checks++;
    if (lat != 33) begin errors++; $display("FAIL udiv_latency got=%0d want=33", lat); end
    checks++;
    if (res !== 64'h00000002_0000000E) begin errors++; $display("FAIL udiv_result got=%h want=000000020000000e", res); end
    held = 1'b1;
    annul_i = 1'b1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      if (ready_o !== 1'b1 || result_o !== 64'h00000002_0000000E) held = 1'b0;
    end
    annul_i = 1'b0;
    checks++;
    if (held !== 1'b1) begin errors++; $display("FAIL end_hold got ready=%b result=%h want ready=1 result=000000020000000e", ready_o, result_o); end
    release_op();
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      errors++; $display("FAIL release_free got ready=%b result=%h want 0/0", ready_o, result_o);
    end
  endtask

  task automatic test_signed();
    logic        t_sgn [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] t_a   [6] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'hFFFFFF9C, 32'hFFFFFFFF, 32'd7};
    logic [31:0] t_b   [6] = '{32'd2, 32'd2, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'd7};
    logic [63:0] t_exp [6] = '{64'hFFFFFFFF_FFFFFFFD, 64'h00000001_7FFFFFFC, 64'h00000002_FFFFFFF2,
                               64'hFFFFFFFE_0000000E, 64'h00000000_00000001, 64'h00000000_00000001};
    int lat;
    logic [63:0] res;
    for (int i = 0; i < 6; i++) begin
      do_div(t_sgn[i], t_a[i], t_b[i], lat, res);
      $display("div sgn=%b %h/%h: lat=%0d result=%h", t_sgn[i], t_a[i], t_b[i], lat, res);
      checks++;
      if (lat != 33 || res !== t_exp[i]) begin
        errors++; $display("FAIL div_vec%0d got lat=%0d result=%h want lat=33 result=%h", i, lat, res, t_exp[i]);
      end
      release_op();
    end
  endtask

  task automatic test_byzero();
    int lat;
    logic [63:0] res;
    do_div(1'b0, 32'd1234, 32'd0, lat, res);
    $display("udiv 1234/0: lat=%0d result=%h", lat, res);
    checks++;
    if (lat != 1 || res !== 64'd0) begin errors++; $display("FAIL byzero_u got lat=%0d result=%h want lat=1 result=0", lat, res); end
    release_op();
    do_div(1'b1, 32'h80000000, 32'd0, lat, res);
    $display("div 80000000/0: lat=%0d result=%h", lat, res);
    checks++;
    if (lat != 1 || res !== 64'd0) begin errors++; $display("FAIL byzero_s got lat=%0d result=%h want lat=1 result=0", lat, res); end
    release_op();
  endtask

  task automatic test_annul();
    int lat;
    logic [63:0] res;
    logic seen;
    // Start together with annul is not accepted.
    signed_div_i = 1'b0; opdata1_i = 32'd50; opdata2_i = 32'd5;
    start_i = 1'b1; annul_i = 1'b1;
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      if (ready_o !== 1'b0) seen = 1'b1;
    end
    start_i = 1'b0; annul_i = 1'b0;
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL annul_start got ready=1 want 0"); end
    // Annul mid-division at edge 10.
    opdata1_i = 32'h1000; opdata2_i = 32'd3; start_i = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      errors++; $display("FAIL annul_on got ready=%b result=%h want 0/0", ready_o, result_o);
    end
    start_i = 1'b0; annul_i = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (ready_o !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL annul_quiet got ready=1 want 0"); end
    do_div(1'b0, 32'd9, 32'd3, lat, res);
    $display("udiv 9/3 after annul: lat=%0d result=%h", lat, res);
    checks++;
    if (lat != 33 || res !== 64'h00000000_00000003) begin
      errors++; $display("FAIL after_annul got lat=%0d result=%h want lat=33 result=3", lat, res);
    end
    release_op();
  endtask

  task automatic test_overflow_reset();
    int lat;
    logic [63:0] res;
    do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, lat, res);
    $display("div 80000000/ffffffff: lat=%0d result=%h", lat, res);
    checks++;
    if (lat != 33 || res !== 64'h00000000_80000000) begin
      errors++; $display("FAIL most_neg got lat=%0d result=%h want lat=33 result=0000000080000000", lat, res);
    end
    release_op();
    signed_div_i = 1'b0; opdata1_i = 32'h12345678; opdata2_i = 32'h11; start_i = 1'b1;
    @(posedge clk);
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      errors++; $display("FAIL rst_mid got ready=%b result=%h want 0/0", ready_o, result_o);
    end
    rst = 1'b0; start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    do_div(1'b0, 32'h12345678, 32'h11, lat, res);
    $display("udiv 12345678/11 after reset: lat=%0d result=%h", lat, res);
    checks++;
    if (lat != 33 || res !== 64'h00000004_01122334) begin
      errors++; $display("FAIL after_rst got lat=%0d result=%h want lat=33 result=0000000401122334", lat, res);
    end
    release_op();
  endtask

  task automatic test_small();
    int lat;
    logic [63:0] res;
    do_div(1'b0, 32'd5, 32'd9, lat, res);
    $display("udiv 5/9: lat=%0d result=%h", lat, res);
    checks++;
    if (lat != SMALL_LAT || res !== 64'h00000005_00000000) begin
      errors++; $display("FAIL small_u got lat=%0d result=%h want lat=%0d result=0000000500000000", lat, res, SMALL_LAT);
    end
    release_op();
    do_div(1'b1, 32'hFFFFFFFB, 32'd9, lat, res);
    $display("div -5/9: lat=%0d result=%h", lat, res);
    checks++;
    if (lat != SMALL_LAT || res !== 64'hFFFFFFFB_00000000) begin
      errors++; $display("FAIL small_s got lat=%0d result=%h want lat=%0d result=fffffffb00000000", lat, res, SMALL_LAT);
    end
    release_op();
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [63:0] res;
    do_div(1'b0, 32'd1000, 32'd10, lat, res);
    $display("b2b 1000/10: lat=%0d result=%h", lat, res);
    checks++;
    if (lat != 33 || res !== 64'h00000000_00000064) begin
      errors++; $display("FAIL b2b_first got lat=%0d result=%h want lat=33 result=64", lat, res);
    end
    release_op();
    do_div(1'b0, 32'd50, 32'd8, lat, res);
    $display("b2b 50/8: lat=%0d result=%h", lat, res);
    checks++;
    if (lat != 33 || res !== 64'h00000002_00000006) begin
      errors++; $display("FAIL b2b_second got lat=%0d result=%h want lat=33 result=0000000200000006", lat, res);
    end
    release_op();
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_byzero();
    test_annul();
    test_overflow_reset();
    test_small();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 restoring integer divider serving DIV/DIVU in the EX stage.
- EX drives `start_i` and raises `stallreq_from_ex` toward the pipeline controller while `ready_o` is low.
- The controller's `flush` output drives `annul_i`, so an exception kills an in-flight division.
- The result is packed HI:LO, remainder in the upper half and quotient in the lower half.

Parameters:
- DATA_W, 32, operand width; quotient and remainder each DATA_W bits.
- CNT_W, 6, iteration counter width; must hold the value DATA_W.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous, active-high.
- signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start.
- opdata1_i  input  DATA_W  dividend; sampled with start.
- opdata2_i  input  DATA_W  divisor; sampled with start.
- start_i  input  1  request; held high by EX until the result has been taken.
- annul_i  input  1  abort in-flight operation (pipeline flush).
- result_o  output  2*DATA_W  {remainder, quotient}; valid only while ready_o = 1.
- ready_o  output  1  result valid.

Behaviour:
- Reset: at any clk edge with rst = 1 → state FREE, cnt = 0, result_o = 0, ready_o = 0, working registers = 0.
  - Reset overrides every other input in every state, including mid-division.
- States: FREE, BYZERO, ON, END (2-bit encoding).
- FREE:
  - start_i = 1, annul_i = 0, divisor = 0 → BYZERO.
  - start_i = 1, annul_i = 0, divisor != 0 → ON.
  - Operand capture on the ON transition: in signed mode, latch absolute values of both operands and record sign_q = sign1 ^ sign2 and sign_r = sign1.
  - Set cnt = 0 and partial remainder = 0.
  - start_i = 1 together with annul_i = 1: request not accepted, stay FREE.
  - ready_o = 0 and result_o = 0 throughout FREE.
- BYZERO:
  - Next edge → END with result_o = 0 and ready_o = 1.
  - annul_i = 1 → FREE instead.
- ON: one iteration per edge.
  - Shift {rem, dividend} left 1.
  - Trial subtract divisor from rem; if non-negative, keep the difference and set quotient bit = 1, else quotient bit = 0.
  - cnt increments by 1 per iteration.
  - Iterations occur at edges 1..DATA_W after the start edge (edge 0).
  - At edge DATA_W+1, with cnt == DATA_W: apply sign correction, two's-complement negate quotient if sign_q, negate remainder if sign_r, unsigned mode never negates; register result_o and set ready_o = 1; → END.
  - Latency start edge to ready_o visible: DATA_W+1 clocks (33 at default).
  - annul_i = 1 at any ON edge → FREE, ready_o = 0, result_o = 0, cnt = 0; no partial result is visible.
- END:
  - Hold result_o and ready_o = 1 while start_i = 1.
  - start_i = 0 → FREE at next edge, ready_o = 0, result_o = 0.
  - annul_i ignored in END.
  - Back-to-back: a new division starts only after one FREE cycle.
- Arithmetic:
  - Magnitude arithmetic on DATA_W+1-bit trial difference; wrap-around of negation is modulo 2^DATA_W.
  - Signed most-negative / -1 yields quotient 0x80000000, remainder 0, with no overflow flag.
- Operand inputs changing after the start edge have no effect.

Optional Feature:
- Macro DIV_EARLY_OUT_EN.
- Defined: in FREE, an accepted start with divisor != 0 and |dividend| < |divisor| (unsigned magnitude compare after abs) goes directly to END.
  - result_o = {original signed/unsigned dividend, 0}, ready_o = 1 after edge 1.
  - Cases where |dividend| == |divisor| or larger take the normal path.
- Not defined: all non-zero-divisor operations take the full DATA_W+1-clock ON path.

Test Plan:
- Unsigned 100 / 7, start held → ready_o rises after edge 33; result_o = 0x00000002_0000000E; ready_o stays 1 until start_i drops, then FREE with result_o = 0.
- Signed 0xFFFFFFF9 (-7) / 2 → result_o = 0xFFFFFFFF_FFFFFFFD after 33 clocks; same operands unsigned → 0x00000001_7FFFFFFC.
- Divisor 0 (any dividend, either mode) → ready_o = 1 after edge 1, result_o = 0.
- Start 0x1000 / 3, annul_i pulsed at edge 10 → FREE at edge 10, ready_o never asserts; a following start with 9 / 3 → 0x00000000_00000003 after 33 clocks.
- Signed 0x80000000 / 0xFFFFFFFF → 0x00000000_80000000; rst asserted at edge 20 of a second division → all outputs 0 at that edge, FREE.
- 5 / 9 unsigned → 0x00000005_00000000; ready after edge 1 with DIV_EARLY_OUT_EN, after edge 33 without.
